// File: rtl/pipe_sub_16bit_pkg.sv
// pipe_sub_16bit_pkg
//   Shared constants and the per-stage register layout for the nibble-serial
//   pipelined subtractor.
//   Contents: WIDTH (operand width), SLICE_W (nibble width), NUM_STAGES,
//             stage_t (one pipeline stage register).
package pipe_sub_16bit_pkg;

    localparam int WIDTH      = 16;
    localparam int SLICE_W    = 4;
    localparam int NUM_STAGES = WIDTH / SLICE_W;

    // One pipeline stage. Finished diff nibbles are shifted in from the top,
    // and the operand remainders are shifted down, so every stage works on
    // bits [3:0] of its source and no stage needs a position-dependent slice.
    typedef struct packed {
        logic             valid;
        logic             carry;  // carry into the next nibble (= ~borrow)
        logic [WIDTH-1:0] diff;   // completed nibbles, newest at the top
        logic [WIDTH-1:0] a;      // unprocessed minuend bits, next nibble at [3:0]
        logic [WIDTH-1:0] b;      // unprocessed subtrahend bits, next nibble at [3:0]
    } stage_t;

endpackage

// File: rtl/pipe_sub_16bit_if.sv
// pipe_sub_16bit_if
//   Operand and result channels of the pipelined subtractor.
//   Handshake: a channel transfers on a rising clk edge where valid && ready.
//   The source holds valid and its payload stable until that transfer; valid
//   never depends on ready. ready may depend combinationally on the sink's
//   downstream ready (out_ready -> in_ready is a legal path).
//   Operand channel : in_valid, in_ready, a, b, bin
//   Result channel  : out_valid, out_ready, diff, bout, ovf, zero
//   Modports        : master (drives operands, accepts results), slave (the subtractor)
interface pipe_sub_16bit_if;
    import pipe_sub_16bit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );

endinterface

// File: rtl/sub_slice_4bit.sv
// sub_slice_4bit
//   One 4-bit carry-lookahead adder slice used as a subtractor nibble:
//   sum = a + b_n + cin, where the caller supplies b_n = ~b and cin = ~borrow.
//   Ports: a, b_n (4-bit operands), cin (carry in), sum (4-bit), cout (carry out).
module sub_slice_4bit
    import pipe_sub_16bit_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b_n,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:1]   c;

    assign g = a & b_n;
    assign p = a ^ b_n;

    // Flattened lookahead: every carry is a two-level function of g, p, cin.
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ {c[3], c[2], c[1], cin};
    assign cout = c[4];

endmodule

// File: rtl/pipe_sub_16bit.sv
// pipe_sub_16bit
//   Four-stage pipelined 16-bit subtractor: diff = a - b - bin (mod 2^16),
//   computed as a + ~b + ~bin one nibble per stage. The last stage register is
//   the output register, so a result appears 4 cycles after its operands are
//   accepted and the pipeline holds at most 4 results.
//   Ports: clk, rst_n (async, active-low), bus (pipe_sub_16bit_if.slave).
//   Flags: bout = unsigned borrow-out, ovf = signed overflow, zero = diff == 0.
//   All result outputs read 0 while out_valid is low.
module pipe_sub_16bit
    import pipe_sub_16bit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    pipe_sub_16bit_if.slave bus
);
    localparam int LAST = NUM_STAGES - 1;

    stage_t                src_s   [NUM_STAGES];  // what each stage loads from
    stage_t                stage_d [NUM_STAGES];
    stage_t                stage_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] ready;                 // stage k may load this cycle
    logic [SLICE_W-1:0]    nib_sum [NUM_STAGES];
    logic [NUM_STAGES-1:0] nib_cout;
    logic                  ovf_d, ovf_q;
    logic                  zero_d, zero_q;

    always_comb begin
        src_s[0] = '{valid: bus.in_valid, carry: ~bus.bin, diff: '0, a: bus.a, b: bus.b};
        for (int k = 1; k < NUM_STAGES; k++) begin
            src_s[k] = stage_q[k-1];
        end
    end

    // A stage may load when it is empty or its content leaves this cycle.
    // Keying on the stage's own valid lets bubbles collapse under a stall.
    always_comb begin
        logic r;
        r           = bus.out_ready || !stage_q[LAST].valid;
        ready[LAST] = r;
        for (int k = LAST - 1; k >= 0; k--) begin
            r        = !stage_q[k].valid || r;
            ready[k] = r;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
        sub_slice_4bit u_slice (
            .a    (src_s[k].a[SLICE_W-1:0]),
            .b_n  (~src_s[k].b[SLICE_W-1:0]),
            .cin  (src_s[k].carry),
            .sum  (nib_sum[k]),
            .cout (nib_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_d[k] = stage_q[k];
            if (ready[k]) begin
                stage_d[k].valid = src_s[k].valid;
                stage_d[k].carry = nib_cout[k];
                stage_d[k].diff  = {nib_sum[k], src_s[k].diff[WIDTH-1:SLICE_W]};
                stage_d[k].a     = {{SLICE_W{1'b0}}, src_s[k].a[WIDTH-1:SLICE_W]};
                stage_d[k].b     = {{SLICE_W{1'b0}}, src_s[k].b[WIDTH-1:SLICE_W]};
            end
        end
    end

    // Flags are resolved while the top nibble is formed: the operand sign bits
    // are bit 3 of the last remainder, and the full diff is known here.
    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (ready[LAST]) begin
            ovf_d  = (src_s[LAST].a[SLICE_W-1] ^ src_s[LAST].b[SLICE_W-1])
                   & (nib_sum[LAST][SLICE_W-1] ^ src_s[LAST].a[SLICE_W-1]);
            zero_d = ({nib_sum[LAST], src_s[LAST].diff[WIDTH-1:SLICE_W]} == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = stage_q[LAST].valid;
    assign bus.diff      = stage_q[LAST].valid ? stage_q[LAST].diff : '0;
    assign bus.bout      = stage_q[LAST].valid & ~stage_q[LAST].carry;
    assign bus.ovf       = stage_q[LAST].valid & ovf_q;
    assign bus.zero      = stage_q[LAST].valid & zero_q;

endmodule
